iob_mem_arbiter: RTL and testbench
==================================

Name: iob_mem_arbiter

Overview:
- Shares one IOb-native memory slave port, such as the int_mem or ext_mem data port, between N_MASTERS IOb-native requesters.
- Typical requesters: the CPU data bus and a DMA or peripheral master.
- One transaction is in flight at a time; grant is round-robin and held until the slave completes.
- Sits between the dbus split output and the memory block.

Parameters:
- N_MASTERS, 2, number of requesters; legal range 2..8.
- ADDR_W, 32, address width of every port.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- GRANT_W, 1, width of the grant index; must equal ceil(log2(N_MASTERS)).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- m_valid  in  N_MASTERS  per-master request valid; held high until that master's m_ready.
- m_addr  in  N_MASTERS*ADDR_W  per-master address; master i occupies bits [i*ADDR_W +: ADDR_W].
- m_wdata  in  N_MASTERS*DATA_W  per-master write data.
- m_wstrb  in  N_MASTERS*DATA_W/8  per-master byte strobes; all-zero means read.
- m_rdata  out  DATA_W  read data, broadcast to all masters; valid only where that master's m_ready is high.
- m_ready  out  N_MASTERS  per-master completion pulse.
- s_valid  out  1  request to the shared slave.
- s_addr  out  ADDR_W  slave address.
- s_wdata  out  DATA_W  slave write data.
- s_wstrb  out  DATA_W/8  slave byte strobes.
- s_rdata  in  DATA_W  slave read data.
- s_ready  in  1  slave completion, one-cycle pulse.
- busy  out  1  high while a transaction is granted.
- grant  out  GRANT_W  index of the current or last granted master.

Behaviour:
- Reset values (async, on rst=1):
  - state=IDLE, rr_ptr=0, grant=0.
  - s_valid=0, m_ready=0, busy=0.
  - s_addr, s_wdata, s_wstrb driven from master 0 fields (don't-care while s_valid=0).
- FSM, two states, IDLE and BUSY.
- IDLE:
  - s_valid=0, m_ready=0.
  - If any m_valid bit is set, pick the winner: the first set bit at or above rr_ptr, scanning upward modulo N_MASTERS.
  - Register the winner into grant and go to BUSY.
  - If no m_valid bit is set, stay in IDLE.
- BUSY:
  - s_valid=1, busy=1.
  - s_addr, s_wdata and s_wstrb are muxed live from master[grant]; masters hold their fields stable until ready.
  - On s_ready=1:
    - m_ready[grant]=1 combinationally in the same cycle; m_rdata=s_rdata.
    - Next state is IDLE.
    - rr_ptr <= (grant+1) mod N_MASTERS; wraps from N_MASTERS-1 to 0.
  - While s_ready=0, stay in BUSY; grant is frozen.
- Latency:
  - m_valid rising to s_valid = 1 cycle.
  - s_ready to m_ready = 0 cycles.
  - Minimum back-to-back issue rate: one transaction every 2 cycles (the IDLE cycle is mandatory between transactions).
- m_ready is a single-cycle pulse, one-hot or zero. Non-granted masters never see m_ready.
- m_rdata is driven from s_rdata at all times; masters qualify it with their own m_ready.
- s_ready while in IDLE is ignored, and no m_ready is generated.
- Simultaneous requests: exactly one winner per arbitration; losers keep m_valid high and win a later turn.
- Starvation bound: a continuously requesting master is granted within N_MASTERS transactions.
- Granted master dropping m_valid before m_ready is a protocol violation. The arbiter keeps s_valid=1 until s_ready; no abort is defined.
- rst asserted mid-transaction: return to IDLE immediately. The in-flight slave access is abandoned; the slave must also be reset by the same rst.
- grant is retained in IDLE; busy distinguishes an active transaction.

Optional Feature:
- Macro: IOB_ARB_FIXED_PRIO_EN.
- Defined:
  - Winner is the lowest-index set m_valid bit; rr_ptr is removed.
  - Master 0 has absolute priority; starvation of higher indices is allowed.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single read: m_valid=01, m_addr0=0x100, m_wstrb0=0 -> s_valid high 1 cycle later with s_addr=0x100, s_wstrb=0. Slave returns s_rdata=0xDEADBEEF with s_ready -> m_ready=01 same cycle, m_rdata=0xDEADBEEF.
- Collision, N_MASTERS=2:
  - Stimulus: m_valid=11 held after reset; master 0 writes 0x11111111 to 0x0, master 1 writes 0x22222222 to 0x4, both wstrb=F.
  - Required: grant order 0,1,0,1 over four transactions; each m_ready one-hot.
  - Without the macro, 0x22222222 reaches s_wdata on the second transaction.
- Wait states: slave holds s_ready low 5 cycles -> s_valid and s_addr stable for 6 cycles, grant unchanged, m_ready=0 until the 6th cycle.
- Wrap-around, N_MASTERS=3: m_valid=111 continuous -> grant sequence 0,1,2,0; rr_ptr wraps from 2 to 0.
- Reset mid-op: assert rst while BUSY, async, mid-cycle -> s_valid=0, busy=0, m_ready=0 immediately. After release, the first grant with m_valid=11 goes to master 0.
- IOB_ARB_FIXED_PRIO_EN defined, m_valid=11 continuous -> master 0 granted on every transaction; master 1 is granted only after m_valid0 drops.

Source files
------------

// File: rtl/iob_mem_arbiter.sv
// iob_mem_arbiter: round-robin arbiter sharing one IOb memory slave among N_MASTERS requesters.
// Define IOB_ARB_FIXED_PRIO_EN to switch to fixed priority (lowest index wins, no rr_ptr).
module iob_mem_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int GRANT_W   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS-1:0]            m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic                            s_valid,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wstrb,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_ready,
  output logic                            busy,
  output logic [GRANT_W-1:0]              grant
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d, winner;
  logic done;
  assign done    = (state_q == BUSY) && s_ready;
  assign s_valid = state_q == BUSY;
  assign busy    = s_valid;
  assign grant   = grant_q;
  assign s_addr  = m_addr[grant_q*ADDR_W +: ADDR_W];
  assign s_wdata = m_wdata[grant_q*DATA_W +: DATA_W];
  assign s_wstrb = m_wstrb[grant_q*(DATA_W/8) +: DATA_W/8];
  assign m_rdata = s_rdata;
  assign m_ready = done ? (N_MASTERS'(1) << grant_q) : '0;
`ifdef IOB_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int i = N_MASTERS-1; i >= 0; i--) if (m_valid[i]) winner = GRANT_W'(i);
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    if (state_q == IDLE && |m_valid) begin
      state_d = BUSY;
      grant_d = winner;
    end
    if (done) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end
`else
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  // lowest requester overall, overridden by the lowest one at or above rr_ptr if any
  always_comb begin
    winner = '0;
    for (int i = N_MASTERS-1; i >= 0; i--) if (m_valid[i]) winner = GRANT_W'(i);
    for (int i = N_MASTERS-1; i >= 0; i--) if (m_valid[i] && GRANT_W'(i) >= rr_ptr_q) winner = GRANT_W'(i);
  end
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (state_q == IDLE && |m_valid) begin
      state_d = BUSY;
      grant_d = winner;
    end
    if (done) begin
      state_d  = IDLE;
      rr_ptr_d = (grant_q == GRANT_W'(N_MASTERS-1)) ? '0 : grant_q + GRANT_W'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif
endmodule

// File: tb/tb_iob_mem_arbiter.sv
// tb_iob_mem_arbiter: directed scoreboard bench for iob_mem_arbiter (2- and 3-master instances).
module tb_iob_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  m_valid;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wstrb;
  logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
  logic [1:0]  m_ready;
  logic        s_valid, s_ready, busy;
  logic [3:0]  s_wstrb;
  logic [0:0]  grant;

  logic [2:0]  m3_valid;
  logic [95:0] m3_addr, m3_wdata;
  logic [11:0] m3_wstrb;
  logic [31:0] m3_rdata, s3_addr, s3_wdata, s3_rdata;
  logic [2:0]  m3_ready;
  logic        s3_valid, s3_ready, busy3;
  logic [3:0]  s3_wstrb;
  logic [1:0]  grant3;

  iob_mem_arbiter #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32), .GRANT_W(1)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready), .s_valid(s_valid),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .s_ready(s_ready), .busy(busy), .grant(grant));

  iob_mem_arbiter #(.N_MASTERS(3), .ADDR_W(32), .DATA_W(32), .GRANT_W(2)) dut3 (
    .clk(clk), .rst(rst), .m_valid(m3_valid), .m_addr(m3_addr), .m_wdata(m3_wdata),
    .m_wstrb(m3_wstrb), .m_rdata(m3_rdata), .m_ready(m3_ready), .s_valid(s3_valid),
    .s_addr(s3_addr), .s_wdata(s3_wdata), .s_wstrb(s3_wstrb), .s_rdata(s3_rdata),
    .s_ready(s3_ready), .busy(busy3), .grant(grant3));

  typedef struct {
    logic [1:0]  g;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int g);
    sb.push_back('{g[1:0], m_addr[g*32 +: 32], m_wdata[g*32 +: 32], m_wstrb[g*4 +: 4]});
  endtask

  task automatic do_txn(input int waits, input logic [31:0] rd);
    exp_t e;
    int n;
    n = 0;
    while (s_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("issue", 64'(s_valid), 64'd1);
    chk("sb_size", 64'(sb.size()), 64'd1);
    e = sb.pop_front();
    chk("grant", 64'(grant), 64'(e.g));
    chk("s_addr", 64'(s_addr), 64'(e.addr));
    chk("s_wdata", 64'(s_wdata), 64'(e.wdata));
    chk("s_wstrb", 64'(s_wstrb), 64'(e.wstrb));
    chk("busy", 64'(busy), 64'd1);
    repeat (waits) begin
      chk("wait_ready", 64'(m_ready), 64'd0);
      chk("wait_valid", 64'(s_valid), 64'd1);
      chk("wait_addr", 64'(s_addr), 64'(e.addr));
      chk("wait_grant", 64'(grant), 64'(e.g));
      @(negedge clk);
    end
    s_rdata = rd;
    s_ready = 1'b1;
    #1;
    chk("m_ready", 64'(m_ready), 64'd1 << e.g);
    chk("m_rdata", 64'(m_rdata), 64'(rd));
    @(posedge clk);
    #1;
    s_ready = 1'b0;
    chk("idle_after", 64'(s_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp3[4];
    rst = 1'b1;
    m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0; s_rdata = '0; s_ready = 1'b0;
    m3_valid = '0; m3_addr = '0; m3_wdata = '0; m3_wstrb = '0; s3_rdata = '0; s3_ready = 1'b0;
    m_addr[31:0] = 32'h100;
    m_addr[63:32] = 32'h200;
    #3;
    chk("rst_s_valid", 64'(s_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_m_ready", 64'(m_ready), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_s_addr", 64'(s_addr), 64'h100);
    @(negedge clk);
    rst = 1'b0;
    // single read, one-cycle issue latency
    m_valid = 2'b01;
    push(0);
    @(negedge clk);
    chk("issue_latency", 64'(s_valid), 64'd1);
    do_txn(0, 32'hDEADBEEF);
    m_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    // collision: both masters write continuously
    m_addr = {32'h4, 32'h0};
    m_wdata = {32'h22222222, 32'h11111111};
    m_wstrb = 8'hFF;
    m_valid = 2'b11;
`ifdef IOB_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) begin push(0); do_txn(0, 32'hA0 + i); end
`else
    for (int i = 0; i < 4; i++) begin push(i % 2); do_txn(0, 32'hA0 + i); end
`endif
    m_valid = 2'b10;
    push(1);
    do_txn(0, 32'hB0);
    // wait states on master 0
    m_valid = 2'b01;
    m_addr[31:0] = 32'h340;
    m_wstrb[3:0] = 4'h0;
    push(0);
    do_txn(5, 32'h12345678);
    m_valid = 2'b00;
    // s_ready while idle is ignored
    @(negedge clk);
    s_ready = 1'b1;
    #1;
    chk("idle_ready_m_ready", 64'(m_ready), 64'd0);
    @(negedge clk);
    chk("idle_ready_busy", 64'(busy), 64'd0);
    s_ready = 1'b0;
    // reset mid-transaction
    m_valid = 2'b11;
    @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
`ifdef IOB_ARB_FIXED_PRIO_EN
    chk("pre_rst_grant", 64'(grant), 64'd0);
`else
    chk("pre_rst_grant", 64'(grant), 64'd1);
`endif
    #2;
    s_ready = 1'b1;
    #1;
    chk("pre_rst_m_ready", 64'(m_ready), 64'd1 << grant);
    rst = 1'b1;
    #1;
    chk("rst_mid_s_valid", 64'(s_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_m_ready", 64'(m_ready), 64'd0);
    @(negedge clk);
    s_ready = 1'b0;
    rst = 1'b0;
    push(0);
    do_txn(0, 32'hC0FFEE00);
    m_valid = 2'b00;
    // three masters: rr pointer wraps from 2 to 0
`ifdef IOB_ARB_FIXED_PRIO_EN
    exp3 = '{0, 0, 0, 0};
`else
    exp3 = '{0, 1, 2, 0};
`endif
    m3_addr = {32'h20, 32'h10, 32'h00};
    m3_valid = 3'b111;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      while (s3_valid !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("n3_issue", 64'(s3_valid), 64'd1);
      chk("n3_grant", 64'(grant3), 64'(exp3[t]));
      chk("n3_s_addr", 64'(s3_addr), 64'(exp3[t] * 16));
      s3_rdata = 32'h300 + t;
      s3_ready = 1'b1;
      #1;
      chk("n3_m_ready", 64'(m3_ready), 64'd1 << exp3[t]);
      chk("n3_m_rdata", 64'(m3_rdata), 64'(32'h300 + t));
      @(posedge clk);
      #1;
      s3_ready = 1'b0;
    end
    m3_valid = '0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
